// File: rtl/ch_capture_ctrl.sv
// Pre/post-trigger capture controller: streams qualified samples into a circular
// buffer and reports where the oldest sample and the trigger sample landed.
module ch_capture_ctrl #(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              arm,
   input  logic              abort,
   input  logic [ADDR_W-1:0] pretrig,
   input  logic [ADDR_W-1:0] posttrig,
   input  logic              s_valid,
   input  logic [DATA_W-1:0] s_data,
   input  logic              trig_in,
   input  logic              force_trig,
   output logic [ADDR_W-1:0] wraddress,
   output logic [DATA_W-1:0] data,
   output logic              wren,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] start_addr,
   output logic [ADDR_W-1:0] trig_addr
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_PRE   = 3'd1;
   localparam logic [2:0] S_ARMED = 3'd2;
   localparam logic [2:0] S_POST  = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

   logic [2:0]        state;
   logic [ADDR_W-1:0] p_len;
   logic [ADDR_W-1:0] q_len;
   logic [ADDR_W-1:0] ptr;
   logic [ADDR_W-1:0] pre_cnt;
   logic [ADDR_W-1:0] post_rem;

   logic vld_p0;
   logic trig_hit;
   logic accept_p0;

   // Zero post-trigger length still captures the trigger sample; the pre and
   // post windows together may not exceed the buffer depth.
   function automatic logic [ADDR_W-1:0] clamp_post(input logic [ADDR_W-1:0] pre,
                                                    input logic [ADDR_W-1:0] post);
      logic [ADDR_W-1:0] q1;
      logic [ADDR_W:0]   sum;
      logic [ADDR_W:0]   room;
      q1   = (post == '0) ? {{(ADDR_W-1){1'b0}}, 1'b1} : post;
      sum  = {1'b0, pre} + {1'b0, q1};
      room = DEPTH - {1'b0, pre};
      if (sum > DEPTH) return room[ADDR_W-1:0];
      return q1;
   endfunction

   assign vld_p0   = s_valid && !abort;
   assign trig_hit = vld_p0 && (trig_in || force_trig);

   // PRE with an empty pre-trigger window hands straight over to ARMED.
   always_comb begin
      accept_p0 = 1'b0;
      case (state)
         S_PRE:   accept_p0 = vld_p0 && (p_len != '0);
         S_ARMED: accept_p0 = vld_p0;
         S_POST:  accept_p0 = vld_p0;
         default: accept_p0 = 1'b0;
      endcase
   end

   // Control stage: state, latched lengths, pointer and result addresses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         p_len      <= '0;
         q_len      <= '0;
         ptr        <= '0;
         pre_cnt    <= '0;
         post_rem   <= '0;
         start_addr <= '0;
         trig_addr  <= '0;
      end else if (abort) begin
         state <= S_IDLE;
      end else begin
         if (accept_p0) ptr <= ptr + 1'b1;
         case (state)
            S_IDLE, S_DONE: begin
               if (arm) begin
                  state   <= S_PRE;
                  p_len   <= pretrig;
                  q_len   <= clamp_post(pretrig, posttrig);
                  ptr     <= '0;
                  pre_cnt <= '0;
               end
            end
            S_PRE: begin
               if (p_len == '0) begin
                  state <= S_ARMED;
               end else if (vld_p0) begin
                  pre_cnt <= pre_cnt + 1'b1;
                  if (pre_cnt == p_len - 1'b1) state <= S_ARMED;
               end
            end
            S_ARMED: begin
               if (trig_hit) begin
                  trig_addr  <= ptr;
                  start_addr <= ptr - p_len;
                  post_rem   <= q_len - 1'b1;
                  state      <= (q_len == {{(ADDR_W-1){1'b0}}, 1'b1}) ? S_DONE : S_POST;
               end
            end
            S_POST: begin
               if (vld_p0) begin
                  post_rem <= post_rem - 1'b1;
                  if (post_rem == {{(ADDR_W-1){1'b0}}, 1'b1}) state <= S_DONE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Write stage: one-cycle registered buffer write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wren      <= 1'b0;
         wraddress <= '0;
         data      <= '0;
      end else begin
         wren <= accept_p0;
         if (accept_p0) begin
            wraddress <= ptr;
            data      <= s_data;
         end
      end
   end

   assign busy = (state == S_PRE) || (state == S_ARMED) || (state == S_POST);
   assign done = (state == S_DONE);

endmodule

// File: tb/tb_ch_capture_ctrl.sv
// Scoreboard bench for ch_capture_ctrl: every expected buffer write is queued as
// the sample is driven and matched against the DUT write port.
module tb_ch_capture_ctrl;

   localparam int ADDR_W = 11;
   localparam int DATA_W = 32;
   localparam int DEPTH  = 2048;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              arm = 1'b0;
   logic              abort = 1'b0;
   logic [ADDR_W-1:0] pretrig = '0;
   logic [ADDR_W-1:0] posttrig = '0;
   logic              s_valid = 1'b0;
   logic [DATA_W-1:0] s_data = '0;
   logic              trig_in = 1'b0;
   logic              force_trig = 1'b0;
   logic [ADDR_W-1:0] wraddress;
   logic [DATA_W-1:0] data;
   logic              wren;
   logic              busy;
   logic              done;
   logic [ADDR_W-1:0] start_addr;
   logic [ADDR_W-1:0] trig_addr;

   typedef struct packed {
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;
   int   wr_count = 0;

   ch_capture_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk(clk), .rst(rst), .arm(arm), .abort(abort),
      .pretrig(pretrig), .posttrig(posttrig),
      .s_valid(s_valid), .s_data(s_data), .trig_in(trig_in), .force_trig(force_trig),
      .wraddress(wraddress), .data(data), .wren(wren),
      .busy(busy), .done(done), .start_addr(start_addr), .trig_addr(trig_addr)
   );

   always #5 clk = ~clk;

   // Write-port monitor: every write must match the head of the scoreboard.
   always @(negedge clk) begin
      if (wren === 1'b1) begin
         exp_t e;
         wr_count++;
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_write addr=%0d data=%h required=no write", wraddress, data);
         end else begin
            e = exp_q.pop_front();
            if (wraddress !== e.a || data !== e.d) begin
               failures++;
               $display("FAIL write_port addr=%0d data=%h required addr=%0d data=%h",
                        wraddress, data, e.a, e.d);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit v, input logic [DATA_W-1:0] d, input bit t,
                        input bit f, input bit ab);
      s_valid = v; s_data = d; trig_in = t; force_trig = f; abort = ab;
      step();
      s_valid = 1'b0; trig_in = 1'b0; force_trig = 1'b0; abort = 1'b0;
   endtask

   task automatic push_exp(input int addr, input logic [DATA_W-1:0] d);
      exp_t e;
      e.a = ADDR_W'(addr % DEPTH);
      e.d = d;
      exp_q.push_back(e);
   endtask

   task automatic do_arm(input int p, input int q, input bit trig_level);
      pretrig = ADDR_W'(p); posttrig = ADDR_W'(q);
      arm = 1'b1; trig_in = trig_level;
      step();
      arm = 1'b0; trig_in = 1'b0;
   endtask

   // trig_from = sample index (1-based) from which the trigger line is held high;
   // 0 means held from the arm cycle onward.
   task automatic run_capture(input string name, input int p, input int q, input int trig_from,
                              input bit use_force, input int gap_pct);
      int qe, tidx, nwr, i, exp_trig, exp_start;
      logic [DATA_W-1:0] d;
      bit t;
      qe = (q == 0) ? 1 : q;
      if (p + qe > DEPTH) qe = DEPTH - p;
      tidx = (trig_from > p + 1) ? trig_from : p + 1;
      nwr = tidx + qe - 1;
      exp_trig = (tidx - 1) % DEPTH;
      exp_start = (tidx - 1 - p + DEPTH) % DEPTH;
      wr_count = 0;
      do_arm(p, q, trig_from == 0);
      if (p == 0) drive(1'b0, '0, trig_from == 0, 1'b0, 1'b0);
      i = 1;
      while (i <= nwr) begin
         if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
            drive(1'b0, $urandom, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'b0);
         end else begin
            d = $urandom;
            t = (trig_from == 0) || (i >= trig_from);
            push_exp(i - 1, d);
            drive(1'b1, d, t && !use_force, t && use_force, 1'b0);
            i++;
         end
      end
      checks++;
      if (done !== 1'b1 || wren !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL %s_done_edge done=%b wren=%b busy=%b required 1 1 0", name, done, wren, busy);
      end
      checks++;
      if (trig_addr !== ADDR_W'(exp_trig)) begin
         failures++;
         $display("FAIL %s_trig_addr got=%0d required=%0d", name, trig_addr, exp_trig);
      end
      checks++;
      if (start_addr !== ADDR_W'(exp_start)) begin
         failures++;
         $display("FAIL %s_start_addr got=%0d required=%0d", name, start_addr, exp_start);
      end
      @(negedge clk);
      #1;
      drive(1'b1, $urandom, 1'b1, 1'b1, 1'b0);
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (wr_count !== nwr || exp_q.size() != 0 || done !== 1'b1) begin
         failures++;
         $display("FAIL %s_count writes=%0d pending=%0d done=%b required writes=%0d pending=0 done=1",
                  name, wr_count, exp_q.size(), done, nwr);
         exp_q.delete();
      end
   endtask

   task automatic test_reset();
      step(); step();
      checks++;
      if (wraddress !== '0 || data !== '0 || wren !== 1'b0 || busy !== 1'b0 ||
          done !== 1'b0 || start_addr !== '0 || trig_addr !== '0) begin
         failures++;
         $display("FAIL reset_outputs wa=%0d d=%h wren=%b busy=%b done=%b sa=%0d ta=%0d required all 0",
                  wraddress, data, wren, busy, done, start_addr, trig_addr);
      end
      rst = 1'b0;
      drive(1'b1, 32'h1234, 1'b1, 1'b1, 1'b0);
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL reset_idle busy=%b done=%b required 0 0", busy, done);
      end
   endtask

   task automatic test_basic();       run_capture("basic", 4, 8, 10, 1'b0, 0);      endtask
   task automatic test_min_window();  run_capture("min", 0, 0, 1, 1'b1, 0);         endtask
   task automatic test_pre_ignore();  run_capture("prehold", 100, 50, 0, 1'b0, 0);  endtask
   task automatic test_gaps();        run_capture("gaps", 3, 5, 7, 1'b0, 40);       endtask
   task automatic test_wrap_clamp();  run_capture("wrap", 2000, 100, 2101, 1'b0, 0); endtask

   task automatic test_abort();
      logic [DATA_W-1:0] d;
      do_arm(2, 8, 1'b0);
      for (int i = 1; i <= 5; i++) begin
         d = $urandom;
         push_exp(i - 1, d);
         drive(1'b1, d, i == 4, 1'b0, 1'b0);
      end
      drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL abort_state busy=%b done=%b required 0 0", busy, done);
      end
      checks++;
      if (trig_addr !== 11'd3 || start_addr !== 11'd1) begin
         failures++;
         $display("FAIL abort_hold ta=%0d sa=%0d required ta=3 sa=1", trig_addr, start_addr);
      end
      drive(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (exp_q.size() != 0 || done !== 1'b0) begin
         failures++;
         $display("FAIL abort_drain pending=%0d done=%b required 0 0", exp_q.size(), done);
         exp_q.delete();
      end
      run_capture("restart", 0, 0, 1, 1'b1, 0);
   endtask

   task automatic test_arm_ignored_and_rst();
      logic [DATA_W-1:0] d;
      do_arm(1, 2, 1'b0);
      d = $urandom; push_exp(0, d); drive(1'b1, d, 1'b0, 1'b0, 1'b0);
      pretrig = 11'd5; posttrig = 11'd5; arm = 1'b1;
      step();
      arm = 1'b0;
      d = $urandom; push_exp(1, d); drive(1'b1, d, 1'b0, 1'b0, 1'b0);
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         failures++;
         $display("FAIL arm_ignored busy=%b done=%b required 1 0", busy, done);
      end
      drive(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
      rst = 1'b1;
      #1;
      checks++;
      if (wraddress !== '0 || data !== '0 || wren !== 1'b0 || busy !== 1'b0 ||
          done !== 1'b0 || start_addr !== '0 || trig_addr !== '0) begin
         failures++;
         $display("FAIL rst_armed wa=%0d d=%h wren=%b busy=%b done=%b sa=%0d ta=%0d required all 0",
                  wraddress, data, wren, busy, done, start_addr, trig_addr);
      end
      step(); step();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) drive(1'b1, $urandom, 1'b1, 1'b1, 1'b0);
      checks++;
      if (busy !== 1'b0 || exp_q.size() != 0) begin
         failures++;
         $display("FAIL rst_abandon busy=%b pending=%0d required 0 0", busy, exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_min_window();
      test_pre_ignore();
      test_gaps();
      test_wrap_clamp();
      test_abort();
      test_arm_ignored_and_rst();
      step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ch_capture_ctrl.md
CH_CAPTURE_CTRL -- requirements
Module: ch_capture_ctrl

Interface
REQ-001 Parameter ADDR_W, default 11, buffer address width (2048 words).
REQ-002 Parameter DATA_W, default 32, sample word width.
REQ-003 clk  input  1  single clock for all logic.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 arm  input  1  single-cycle pulse that starts a capture.
REQ-006 abort  input  1  cancels the capture in progress.
REQ-007 pretrig  input  ADDR_W  samples kept before the trigger, latched on arm.
REQ-008 posttrig  input  ADDR_W  samples written at and after the trigger, latched on arm.
REQ-009 s_valid  input  1  sample strobe.
REQ-010 s_data  input  DATA_W  sample word.
REQ-011 trig_in  input  1  trigger condition, qualified by s_valid.
REQ-012 force_trig  input  1  software trigger, qualified by s_valid.
REQ-013 wraddress  output  ADDR_W  buffer write address.
REQ-014 data  output  DATA_W  buffer write data.
REQ-015 wren  output  1  buffer write enable.
REQ-016 busy  output  1  high in states PRE, ARMED and POST.
REQ-017 done  output  1  high in state DONE.
REQ-018 start_addr  output  ADDR_W  address of the oldest captured sample.
REQ-019 trig_addr  output  ADDR_W  address of the trigger sample.

Function
REQ-020 States are IDLE, PRE, ARMED, POST and DONE.
REQ-021 The state SHALL move from IDLE or DONE to PRE on arm; arm SHALL be ignored in every other state.
REQ-022 On arm, pretrig SHALL be latched as P, posttrig as Q, and the write pointer SHALL be cleared to 0.
REQ-023 Q=0 SHALL be treated as 1; if P+Q>2048, Q SHALL be clamped to 2048-P.
REQ-024 In PRE, ARMED and POST, every s_valid cycle SHALL register s_data into data and the pointer into wraddress, and assert wren for exactly the next cycle.
REQ-025 The pointer SHALL then increment modulo 2^ADDR_W (2047 wraps to 0).
REQ-026 Write latency SHALL be 1 cycle; wren SHALL never assert in IDLE or DONE.
REQ-027 PRE SHALL end, moving to ARMED, once P samples are written; with P=0 the state SHALL go directly from PRE to ARMED in the cycle after arm.
REQ-028 Triggers in PRE SHALL be ignored.
REQ-029 In ARMED, an s_valid cycle with trig_in or force_trig high SHALL be the trigger sample.
REQ-030 The trigger sample SHALL be written, trig_addr SHALL take its address, and start_addr SHALL take (trigger address - P) mod 2048.
REQ-031 The trigger sample SHALL count as the first of the Q post-trigger samples.
REQ-032 If Q=1, the state SHALL go from ARMED directly to DONE; otherwise it SHALL enter POST.
REQ-033 POST SHALL move to DONE on the cycle its last post-trigger sample is accepted; the final wren SHALL assert in the first DONE cycle.
REQ-034 In ARMED, the buffer SHALL keep wrapping indefinitely until a trigger occurs.
REQ-035 Abort SHALL have priority over arm, trigger and s_valid in the same cycle.
REQ-036 On abort, the state SHALL go to IDLE, that cycle's sample SHALL NOT be written, and start_addr and trig_addr SHALL hold their values.
REQ-037 A write already registered before the abort cycle SHALL still complete.
REQ-038 Samples between s_valid strobes SHALL be ignored; s_valid may be high every cycle.
REQ-039 start_addr and trig_addr SHALL be stable from DONE until the next arm.

Reset
REQ-040 While rst is high: state IDLE; wraddress, data, wren, busy, done, start_addr, trig_addr = 0; latched P and Q = 0.
REQ-041 Reset asserted mid-capture SHALL abandon the capture with no further writes.
REQ-042 After rst falls, the block SHALL wait in IDLE for arm.

Verification
REQ-043 P=4, Q=8, s_valid continuous, trig_in high with the 10th sample -> trigger at address 9; start_addr=5; trig_addr=9; 17 writes to addresses 0..16; done after the write to 16.
REQ-044 P=0, Q=0, force_trig on the 1st sample -> exactly 1 write at address 0; start_addr=0; trig_addr=0; done.
REQ-045 P=100, Q=50, trigger held from the arm cycle -> no trigger until 100 samples are written; trig_addr=100; start_addr=0.
REQ-046 P=2000, Q=100, 2100 samples before the trigger -> wrap from 2047 to 0; trig_addr=2100 mod 2048=52; start_addr=100; Q clamped to 48; last write at 99.
REQ-047 Abort in POST while s_valid is high -> busy=0 next cycle; no write at that address; done stays 0; a subsequent arm restarts from address 0.
REQ-048 arm pulsed in ARMED -> ignored; rst in ARMED -> all outputs 0 immediately.
